uart_tx: RTL
============

# uart_tx

Serial transmitter for the RS232 link: accepts a parallel byte over a start/busy handshake and shifts it out as one 8N1 frame: start bit low, 8 data bits LSB first, one stop bit high. It is the transmit-side counterpart of the Rx control FSM. It shares the baud timing convention with that FSM: one bit period is a fixed number of `clk` cycles. It contains its own bit-time counter, bit counter and shift register, so the top level only wires it between the host logic and the `tx` pin.

## Interface
- `CLKS_PER_BIT`, default 5208: `clk` cycles per bit (50 MHz / 9600 baud). Legal range is ≥ 2.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `tx_start`, input, 1: request to send `tx_data`; sampled only in IDLE.
- `tx_data`, input, 8: byte to send; captured on the cycle `tx_start` is accepted.
- `tx`, output, 1: serial line; registered; idles high.
- `tx_busy`, output, 1: high from the cycle after acceptance until the cycle after DONE.
- `tx_done`, output, 1: one-cycle pulse after the stop bit completes.

## Operation
- Reset: while `rst_n`=0 at a rising edge, the next state is IDLE, with `tx`=1, `tx_busy`=0, `tx_done`=0, and the bit-time counter, bit counter and shift register all cleared. This applies mid-frame: the frame is abandoned and no `tx_done` is generated.
- States: IDLE, START, DATA, STOP, DONE.
  - IDLE: `tx`=1. If `tx_start`=1, load the shift register with `tx_data`, clear the bit-time counter, and go to START.
  - START: `tx`=0. When the bit-time counter reaches `CLKS_PER_BIT`-1, clear the counter and the bit counter, and go to DATA.
  - DATA: `tx`=shift[0]. At each bit-time end, shift right by 1 and increment the bit counter. When the bit counter is 7 at a bit-time end, go to STOP.
  - STOP: `tx`=1. At bit-time end, go to DONE.
  - DONE: `tx`=1, `tx_done`=1 for exactly this cycle. Unconditionally go to IDLE.
- Bit-time counter: width `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, wraps to 0, and is cleared on every state entry.
- Bit counter: 3 bits, 0..7. It never wraps inside a frame.
- `tx_start` in any state other than IDLE is ignored, and so is `tx_start` in the DONE cycle. There is no queueing.
- `tx_data` changes after acceptance do not affect the frame in flight.
- Outputs come from registers: no combinational path from inputs to `tx`, `tx_busy` or `tx_done`.

## Timing
- Acceptance edge is T (IDLE with `tx_start`=1). Let N = `CLKS_PER_BIT`.
- Start bit: `tx`=0 over cycles T+1 .. T+N.
- Data bit k (k=0..7): cycles T+1+(k+1)N .. T+(k+2)N.
- Stop bit: cycles T+1+9N .. T+10N.
- `tx_done`=1 at cycle T+10N+1. `tx_busy`=1 over cycles T+1 .. T+10N+1.
- The next `tx_start` can be accepted at T+10N+2, so the minimum frame-to-frame period is 10N+2 cycles.
- `tx` never glitches: it changes only at state or bit boundaries.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (3-bit);
  - `UART_DATA_BITS`=8;
  - default `CLKS_PER_BIT`;
  - Rx and Tx both import it.
- Sub-module `uart_baud_counter`:
  - parameter `CLKS_PER_BIT`; inputs `clk`, `rst_n`, `clr`; output `end_bit_time`;
  - reusable by the Rx path.
- FSM, shift register and bit counter live in `uart_tx`.

## Test plan
- With N=4: reset, then `tx_start` with `tx_data`=8'hA5 → `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses at T+41 and `tx_busy` falls at T+42.
- With N=4: back-to-back sends of 8'h00 then 8'hFF, the second `tx_start` held high continuously → the second start bit begins at T+43 and both frames are bit-exact.
- `tx_start` pulsed at T+5 and at T+41 (the DONE cycle) during a frame → ignored, with exactly one frame and one `tx_done`.
- `tx_data` changed to 8'h3C at T+2 while sending 8'hC3 → the line carries 8'hC3.
- `rst_n`=0 for one cycle during data bit 3 → `tx`=1 and `tx_busy`=0 the next cycle, no `tx_done`, and a new `tx_start` is accepted the cycle after.
- With N=2 (minimum): send 8'h55 → 20-cycle frame, `tx_done` at T+21.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default baud timing.
// Imported by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  // 50 MHz clock at 9600 baud
  localparam int unsigned UART_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StDone  = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// Shared by the Tx and Rx paths.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic end_bit_time
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign end_bit_time = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: accepts a byte on tx_start while idle and shifts it out LSB first.
// All outputs are registered from the next-state values so tx never glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int unsigned BitCntW = $clog2(UART_DATA_BITS);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      baud_clr;
  logic                      end_bit_time;

  // Counter restarts on every state entry and is held at zero while idle.
  assign baud_clr = (state_q == StIdle) || (state_d != state_q);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (baud_clr),
    .end_bit_time(end_bit_time)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          shift_d = tx_data;
          state_d = StStart;
        end
      end
      StStart: begin
        if (end_bit_time) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (end_bit_time) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (end_bit_time) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the state being entered, then registered.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == StStart) begin
      tx_d = 1'b0;
    end else if (state_d == StData) begin
      tx_d = shift_d[0];
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
